router_pkt_tx: RTL and testbench
================================

# router_pkt_tx

Packet source for the 1x3 router: accepts a destination address, a length and a payload from a byte-stream source, buffers the whole payload, then drives the router input port with header byte, payload bytes and an XOR parity byte under router `busy` back-pressure. It sits upstream of the router input and is the transmitting end of the packet protocol the router register and FSM receive. Because it buffers first, a packet on the wire never underflows mid-transfer.

## Interface
- `MAX_LEN`, 63: largest legal payload length in bytes; sets buffer depth; must be ≤ 63.
- `GAP`, 2: idle cycles forced between end of parity byte and next `ready`; 0 allowed.

- `clk`  in  1  single clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  request pulse; sampled only when `ready`=1.
- `dest_addr`  in  2  destination port, 0..2; 3 is illegal.
- `pkt_len`  in  6  payload length, 1..MAX_LEN.
- `inject_err`  in  1  sampled with `start`; used only when the error-injection build option is on.
- `ready`  out  1  high in IDLE: a new request may be issued.
- `src_data`  in  8  payload byte from source.
- `src_valid`  in  1  `src_data` valid.
- `src_ready`  out  1  high in LOAD; byte taken when `src_valid`&`src_ready`.
- `busy`  in  1  router back-pressure; while high, the current output byte is held.
- `data_out`  out  8  byte to the router `data_in`.
- `pkt_valid`  out  1  high for header and payload bytes, low for the parity byte.
- `done`  out  1  one-cycle pulse when the parity byte is accepted.

## Operation
- States: IDLE, LOAD, HEADER, PAYLOAD, PARITY, GAP.
- IDLE: `ready`=1.
  - `start`, legal `dest_addr` (≠3) and `pkt_len` in 1..MAX_LEN: latch address, length and inject flag; clear byte count; set parity = header; go to LOAD.
  - Illegal request: ignored; state stays IDLE.
- Header byte = {`pkt_len`[5:0], `dest_addr`[1:0]}.
- LOAD:
  - `src_ready`=1.
  - Each accepted byte is written to buffer[count], XORed into parity and increments count.
  - When count reaches `pkt_len`, go to HEADER.
  - Source stalls (`src_valid`=0) only extend LOAD.
- HEADER: `data_out`=header, `pkt_valid`=1. On a cycle with `busy`=0, go to PAYLOAD with read index 0.
- PAYLOAD:
  - `data_out`=buffer[idx], `pkt_valid`=1.
  - On a cycle with `busy`=0, increment idx.
  - After byte `pkt_len`-1 is accepted, go to PARITY.
- PARITY: `data_out`=parity, `pkt_valid`=0. On a cycle with `busy`=0, pulse `done` and go to GAP.
- GAP: `data_out`=0, `pkt_valid`=0 for GAP cycles, then IDLE. If GAP=0, go directly to IDLE.
- Parity is the 8-bit XOR of the header and all payload bytes, matching the router's internal parity.
- Counters are 6-bit and cannot wrap, since `pkt_len` ≤ 63.

## Timing
- Reset values: state IDLE, `ready`=1, `src_ready`=0, `data_out`=0, `pkt_valid`=0, `done`=0; parity and counters 0.
- Buffer contents are not cleared by reset.
- Reset mid-packet aborts immediately. The router may see a truncated packet; the transmitter does not try to recover it.
- All outputs are registered, with no combinational path from input to output.
- `start` accepted at edge T → `src_ready`=1 from T+1.
- Last LOAD byte accepted at edge L → header on `data_out` from L+1.
- With `busy`=0 throughout, the wire carries `pkt_len`+2 consecutive bytes: header, payload, parity.
- `busy` sampled high holds `data_out` and `pkt_valid` unchanged on the next cycle. `busy` is honoured in HEADER, PAYLOAD and PARITY.
- `done` is high for exactly one cycle: the cycle after the parity byte is accepted.
- Simultaneous `start` and `reset`: reset wins.
- `start` outside IDLE is ignored.

## Configuration
- `ROUTER_TX_ERRINJ_EN` defined: if the latched `inject_err`=1, the transmitted parity byte is the true parity with bit 0 inverted. The router should then flag `error`.
- Undefined: `inject_err` is ignored, with no logic behind it, and the true parity is always sent.

## Test plan
- Legal packet: addr 1, len 3, payload 0x11,0x22,0x33, `busy`=0 → wire shows 0x0D(v=1), 0x11, 0x22, 0x33 (v=1), then 0x0D(v=0). `done` pulses one cycle later.
- Back-pressure: same packet with `busy`=1 for 2 cycles during the 0x22 byte → 0x22 held 3 cycles. Sequence and parity are unchanged.
- Illegal requests: `dest_addr`=3 or `pkt_len`=0 → `ready` stays 1, `pkt_valid` never rises.
- Max length: len 63 with incrementing payload 0x00..0x3E → 65 wire bytes. Parity = 0xFE ^ XOR(0x00..0x3E).
- Reset in PAYLOAD after 2 bytes → next cycle `pkt_valid`=0, `data_out`=0, `ready`=1. A following packet is sent correctly.
- With `ROUTER_TX_ERRINJ_EN` defined, `inject_err`=1 on the first packet → parity byte 0x0C. Without the macro → 0x0D.

Source files
------------

// File: rtl/router_pkt_tx.sv
// Buffered packet source for the 1x3 router: loads a payload, then sends header, payload and XOR parity under busy.
// Build option ROUTER_TX_ERRINJ_EN: when defined, a latched inject_err flips bit 0 of the transmitted parity.
module router_pkt_tx #(
    parameter int MAX_LEN = 63,
    parameter int GAP     = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [1:0] dest_addr,
    input  logic [5:0] pkt_len,
    input  logic       inject_err,
    output logic       ready,
    input  logic [7:0] src_data,
    input  logic       src_valid,
    output logic       src_ready,
    input  logic       busy,
    output logic [7:0] data_out,
    output logic       pkt_valid,
    output logic       done
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_HEADER,
        S_PAYLOAD,
        S_PARITY,
        S_GAP
    } state_t;

    state_t     state;
    logic [5:0] len_q;
    logic [5:0] count;
    logic [5:0] idx;
    logic [7:0] header_q;
    logic [7:0] parity;
    logic [7:0] gap_cnt;
    logic [7:0] buffer [0:MAX_LEN-1];
    logic       req_ok;
    logic       take;

`ifdef ROUTER_TX_ERRINJ_EN
    logic inj_q;

    function automatic logic [7:0] corrupt_parity(input logic [7:0] p, input logic inj);
        return p ^ {7'd0, inj};
    endfunction
`else
    logic unused_inject;
    assign unused_inject = inject_err;
`endif

    assign req_ok = start && (dest_addr != 2'd3) && (pkt_len != 6'd0)
                    && ({1'b0, pkt_len} <= 7'(MAX_LEN));
    assign take   = (state == S_LOAD) && src_valid && src_ready;

    // Payload store has no reset; it is always fully rewritten before it is read.
    always_ff @(posedge clk) begin
        if (take) buffer[count] <= src_data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            ready     <= 1'b1;
            src_ready <= 1'b0;
            data_out  <= 8'd0;
            pkt_valid <= 1'b0;
            done      <= 1'b0;
            len_q     <= 6'd0;
            count     <= 6'd0;
            idx       <= 6'd0;
            header_q  <= 8'd0;
            parity    <= 8'd0;
            gap_cnt   <= 8'd0;
`ifdef ROUTER_TX_ERRINJ_EN
            inj_q     <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (req_ok) begin
                        len_q     <= pkt_len;
                        header_q  <= {pkt_len, dest_addr};
                        parity    <= {pkt_len, dest_addr};
                        count     <= 6'd0;
`ifdef ROUTER_TX_ERRINJ_EN
                        inj_q     <= inject_err;
`endif
                        ready     <= 1'b0;
                        src_ready <= 1'b1;
                        state     <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (take) begin
                        parity <= parity ^ src_data;
                        count  <= count + 6'd1;
                        // Header goes out the cycle after the last payload byte lands.
                        if (count + 6'd1 == len_q) begin
                            src_ready <= 1'b0;
                            data_out  <= header_q;
                            pkt_valid <= 1'b1;
                            state     <= S_HEADER;
                        end
                    end
                end
                S_HEADER: begin
                    if (!busy) begin
                        idx      <= 6'd0;
                        data_out <= buffer[0];
                        state    <= S_PAYLOAD;
                    end
                end
                S_PAYLOAD: begin
                    if (!busy) begin
                        if (idx + 6'd1 == len_q) begin
`ifdef ROUTER_TX_ERRINJ_EN
                            data_out <= corrupt_parity(parity, inj_q);
`else
                            data_out <= parity;
`endif
                            pkt_valid <= 1'b0;
                            state     <= S_PARITY;
                        end else begin
                            idx      <= idx + 6'd1;
                            data_out <= buffer[idx + 6'd1];
                        end
                    end
                end
                S_PARITY: begin
                    if (!busy) begin
                        done     <= 1'b1;
                        data_out <= 8'd0;
                        gap_cnt  <= 8'd0;
                        if (GAP == 0) begin
                            ready <= 1'b1;
                            state <= S_IDLE;
                        end else begin
                            state <= S_GAP;
                        end
                    end
                end
                S_GAP: begin
                    if (gap_cnt == 8'(GAP - 1)) begin
                        ready <= 1'b1;
                        state <= S_IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + 8'd1;
                    end
                end
                default: begin
                    ready <= 1'b1;
                    state <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_router_pkt_tx.sv
// Self-checking bench for router_pkt_tx: randomized packets compared against an expected-wire model.
module tb_router_pkt_tx;
    localparam int MAX_LEN = 63;
    localparam int GAP     = 2;
`ifdef ROUTER_TX_ERRINJ_EN
    localparam bit ERRINJ = 1'b1;
`else
    localparam bit ERRINJ = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset, start, inject_err, src_valid, busy;
    logic [1:0] dest_addr;
    logic [5:0] pkt_len;
    logic [7:0] src_data;
    logic       ready, src_ready, pkt_valid, done;
    logic [7:0] data_out;

    int checks = 0;
    int passed = 0;

    logic [7:0] pay[$];
    logic [7:0] exp_d[$];
    logic [7:0] obs_d[$];
    logic       exp_v[$];
    logic       obs_v[$];
    logic       srdy_after_start, hdr_v, done_now;
    logic [7:0] hdr_d, data_after;
    int         wire_cycles, hold_viol, done_early, done_cnt, gap_seen, srdy_viol;
    bit         timed_out;

    router_pkt_tx #(.MAX_LEN(MAX_LEN), .GAP(GAP)) dut (
        .clk(clk), .reset(reset), .start(start), .dest_addr(dest_addr), .pkt_len(pkt_len),
        .inject_err(inject_err), .ready(ready), .src_data(src_data), .src_valid(src_valid),
        .src_ready(src_ready), .busy(busy), .data_out(data_out), .pkt_valid(pkt_valid), .done(done)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected wire: header {len,addr}, payload bytes, then XOR of everything before it.
    function automatic void build_exp(input logic [1:0] a, input logic [5:0] l, input logic inj);
        logic [7:0] p;
        exp_d.delete();
        exp_v.delete();
        p = {l, a};
        exp_d.push_back(p);
        exp_v.push_back(1'b1);
        for (int i = 0; i < int'(l); i++) begin
            exp_d.push_back(pay[i]);
            exp_v.push_back(1'b1);
            p = p ^ pay[i];
        end
        if (inj && ERRINJ) p[0] = ~p[0];
        exp_d.push_back(p);
        exp_v.push_back(1'b0);
    endfunction

    task automatic send_pkt(input logic [1:0] a, input logic [5:0] l, input logic inj,
                            input int busy_mode, input bit stalls);
        int         k, i, bcnt;
        logic       b, cur_v;
        logic [7:0] cur_d;
        bit         gap_open;
        obs_d.delete();
        obs_v.delete();
        timed_out = 0; wire_cycles = 0; hold_viol = 0; done_early = 0;
        done_cnt = 0; gap_seen = 0; srdy_viol = 0; bcnt = 0;
        k = 0;
        while (!ready && k < 50) begin step(); k++; end
        if (!ready) timed_out = 1;
        dest_addr = a; pkt_len = l; inject_err = inj; start = 1'b1;
        step();
        start = 1'b0;
        srdy_after_start = src_ready;
        i = 0; k = 0;
        while (i < int'(l) && k < 1000) begin
            if (stalls && $urandom_range(0, 3) == 0) src_valid = 1'b0;
            else begin src_valid = 1'b1; src_data = pay[i]; end
            if (src_valid && !src_ready) srdy_viol++;
            step();
            if (src_valid) i++;
            k++;
        end
        src_valid = 1'b0;
        hdr_d = data_out;
        hdr_v = pkt_valid;
        k = 0;
        while (obs_d.size() < int'(l) + 2 && k < 2000) begin
            b = 1'b0;
            if (busy_mode == 1) b = ($urandom_range(0, 2) == 0);
            else if (busy_mode == 2 && obs_d.size() == 2 && bcnt < 2) begin b = 1'b1; bcnt++; end
            busy = b;
            if (stalls) start = 1'($urandom_range(0, 1));
            if (done) done_early++;
            cur_d = data_out;
            cur_v = pkt_valid;
            step();
            wire_cycles++;
            k++;
            if (b) begin
                if (data_out !== cur_d || pkt_valid !== cur_v) hold_viol++;
            end else begin
                obs_d.push_back(cur_d);
                obs_v.push_back(cur_v);
            end
        end
        busy = 1'b0;
        start = 1'b0;
        if (obs_d.size() < int'(l) + 2) timed_out = 1;
        done_now = done;
        data_after = data_out;
        gap_open = 1;
        for (int c = 0; c < GAP + 3; c++) begin
            if (done) done_cnt++;
            if (gap_open && !ready) gap_seen++;
            else gap_open = 0;
            step();
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b1; dest_addr = 2'd1; pkt_len = 6'd3; inject_err = 1'b0;
        src_valid = 1'b0; src_data = 8'd0; busy = 1'b0;
        step();
        step();
        checks++; if (ready !== 1'b1) $display("FAIL reset_ready: got %b expected 1", ready); else passed++;
        checks++; if (src_ready !== 1'b0) $display("FAIL reset_src_ready: got %b expected 0", src_ready); else passed++;
        checks++; if (data_out !== 8'd0) $display("FAIL reset_data_out: got %h expected 00", data_out); else passed++;
        checks++; if (pkt_valid !== 1'b0 || done !== 1'b0)
            $display("FAIL reset_valid_done: got %b/%b expected 0/0", pkt_valid, done); else passed++;
        reset = 1'b0;
        start = 1'b0;
        step();
        checks++; if (ready !== 1'b1 || src_ready !== 1'b0)
            $display("FAIL reset_beats_start: ready/src_ready got %b/%b expected 1/0", ready, src_ready); else passed++;
    endtask

    task automatic test_basic();
        pay = '{8'h11, 8'h22, 8'h33};
        build_exp(2'd1, 6'd3, 1'b0);
        send_pkt(2'd1, 6'd3, 1'b0, 0, 0);
        checks++; if (timed_out) $display("FAIL basic_timeout: got incomplete packet required complete"); else passed++;
        checks++; if (srdy_after_start !== 1'b1) $display("FAIL basic_src_ready_latency: got %b expected 1", srdy_after_start); else passed++;
        checks++; if (hdr_d !== 8'h0D || hdr_v !== 1'b1)
            $display("FAIL basic_header_latency: got %h/%b expected 0d/1", hdr_d, hdr_v); else passed++;
        checks++; if (obs_d.size() != 5) $display("FAIL basic_len: got %0d bytes expected 5", obs_d.size()); else passed++;
        for (int i = 0; i < obs_d.size() && i < exp_d.size(); i++) begin
            checks++;
            if (obs_d[i] !== exp_d[i] || obs_v[i] !== exp_v[i])
                $display("FAIL basic_byte%0d: got %h/v%b expected %h/v%b", i, obs_d[i], obs_v[i], exp_d[i], exp_v[i]);
            else passed++;
        end
        checks++; if (wire_cycles != 5) $display("FAIL basic_consecutive: got %0d cycles expected 5", wire_cycles); else passed++;
        checks++; if (done_now !== 1'b1 || done_cnt != 1)
            $display("FAIL basic_done: got now=%b count=%0d expected 1/1", done_now, done_cnt); else passed++;
        checks++; if (done_early != 0) $display("FAIL basic_done_early: got %0d expected 0", done_early); else passed++;
        checks++; if (gap_seen != GAP) $display("FAIL basic_gap: got %0d expected %0d", gap_seen, GAP); else passed++;
        checks++; if (data_after !== 8'd0) $display("FAIL basic_gap_data: got %h expected 00", data_after); else passed++;
    endtask

    task automatic test_backpressure();
        pay = '{8'h11, 8'h22, 8'h33};
        build_exp(2'd1, 6'd3, 1'b0);
        send_pkt(2'd1, 6'd3, 1'b0, 2, 0);
        checks++; if (timed_out) $display("FAIL bp_timeout: got incomplete packet required complete"); else passed++;
        checks++; if (hold_viol != 0) $display("FAIL bp_hold: got %0d changes under busy expected 0", hold_viol); else passed++;
        checks++; if (wire_cycles != 7) $display("FAIL bp_cycles: got %0d expected 7", wire_cycles); else passed++;
        for (int i = 0; i < obs_d.size() && i < exp_d.size(); i++) begin
            checks++;
            if (obs_d[i] !== exp_d[i] || obs_v[i] !== exp_v[i])
                $display("FAIL bp_byte%0d: got %h/v%b expected %h/v%b", i, obs_d[i], obs_v[i], exp_d[i], exp_v[i]);
            else passed++;
        end
        checks++; if (done_cnt != 1) $display("FAIL bp_done: got %0d pulses expected 1", done_cnt); else passed++;
    endtask

    task automatic test_illegal();
        int vcnt;
        for (int t = 0; t < 2; t++) begin
            dest_addr = (t == 0) ? 2'd3 : 2'd1;
            pkt_len   = (t == 0) ? 6'd5 : 6'd0;
            start = 1'b1;
            step();
            start = 1'b0;
            checks++; if (ready !== 1'b1 || src_ready !== 1'b0)
                $display("FAIL illegal%0d_accept: ready/src_ready got %b/%b expected 1/0", t, ready, src_ready); else passed++;
            vcnt = 0;
            for (int c = 0; c < 6; c++) begin
                if (pkt_valid !== 1'b0 || src_ready !== 1'b0) vcnt++;
                step();
            end
            checks++; if (vcnt != 0) $display("FAIL illegal%0d_activity: got %0d active cycles expected 0", t, vcnt); else passed++;
        end
    endtask

    task automatic test_max_len();
        pay.delete();
        for (int i = 0; i < 63; i++) pay.push_back(8'(i));
        build_exp(2'd2, 6'd63, 1'b0);
        send_pkt(2'd2, 6'd63, 1'b0, 0, 0);
        checks++; if (timed_out) $display("FAIL max_timeout: got incomplete packet required complete"); else passed++;
        checks++; if (obs_d.size() != 65 || wire_cycles != 65)
            $display("FAIL max_len: got %0d bytes in %0d cycles expected 65/65", obs_d.size(), wire_cycles); else passed++;
        checks++; if (hdr_d !== 8'hFE) $display("FAIL max_header: got %h expected fe", hdr_d); else passed++;
        checks++; if (obs_d[obs_d.size()-1] !== 8'hC1) $display("FAIL max_parity: got %h expected c1", obs_d[obs_d.size()-1]); else passed++;
        for (int i = 0; i < obs_d.size() && i < exp_d.size(); i++) begin
            checks++;
            if (obs_d[i] !== exp_d[i] || obs_v[i] !== exp_v[i])
                $display("FAIL max_byte%0d: got %h/v%b expected %h/v%b", i, obs_d[i], obs_v[i], exp_d[i], exp_v[i]);
            else passed++;
        end
    endtask

    task automatic test_reset_mid();
        int k;
        pay.delete();
        for (int i = 0; i < 5; i++) pay.push_back(8'($urandom_range(0, 255)));
        k = 0;
        while (!ready && k < 50) begin step(); k++; end
        dest_addr = 2'd0; pkt_len = 6'd5; inject_err = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 5; i++) begin src_valid = 1'b1; src_data = pay[i]; step(); end
        src_valid = 1'b0;
        busy = 1'b0;
        step(); step(); step();
        checks++; if (pkt_valid !== 1'b1 || data_out !== pay[2])
            $display("FAIL rstmid_pre: got %h/v%b expected %h/v1", data_out, pkt_valid, pay[2]); else passed++;
        reset = 1'b1;
        step();
        reset = 1'b0;
        checks++; if (pkt_valid !== 1'b0 || data_out !== 8'd0)
            $display("FAIL rstmid_wire: got %h/v%b expected 00/v0", data_out, pkt_valid); else passed++;
        checks++; if (ready !== 1'b1 || src_ready !== 1'b0 || done !== 1'b0)
            $display("FAIL rstmid_ctrl: ready/src_ready/done got %b%b%b expected 100", ready, src_ready, done); else passed++;
        pay = '{8'hA5, 8'h3C, 8'hFF, 8'h01};
        build_exp(2'd2, 6'd4, 1'b0);
        send_pkt(2'd2, 6'd4, 1'b0, 0, 0);
        checks++; if (timed_out || obs_d.size() != 6)
            $display("FAIL rstmid_next_len: got %0d bytes expected 6", obs_d.size()); else passed++;
        for (int i = 0; i < obs_d.size() && i < exp_d.size(); i++) begin
            checks++;
            if (obs_d[i] !== exp_d[i] || obs_v[i] !== exp_v[i])
                $display("FAIL rstmid_byte%0d: got %h/v%b expected %h/v%b", i, obs_d[i], obs_v[i], exp_d[i], exp_v[i]);
            else passed++;
        end
    endtask

    task automatic test_errinj();
        pay = '{8'h11, 8'h22, 8'h33};
        send_pkt(2'd1, 6'd3, 1'b1, 0, 0);
        checks++; if (timed_out || obs_d.size() != 5)
            $display("FAIL errinj_len: got %0d bytes expected 5", obs_d.size()); else passed++;
        checks++; if (obs_d[obs_d.size()-1] !== (ERRINJ ? 8'h0C : 8'h0D))
            $display("FAIL errinj_parity: got %h expected %h", obs_d[obs_d.size()-1], ERRINJ ? 8'h0C : 8'h0D); else passed++;
        pay = '{8'h11, 8'h22, 8'h33};
        send_pkt(2'd1, 6'd3, 1'b0, 0, 0);
        checks++; if (obs_d[obs_d.size()-1] !== 8'h0D)
            $display("FAIL errinj_clear: got %h expected 0d", obs_d[obs_d.size()-1]); else passed++;
    endtask

    task automatic test_random();
        logic [1:0] a;
        logic [5:0] l;
        logic       inj;
        for (int n = 0; n < 8; n++) begin
            a   = 2'($urandom_range(0, 2));
            l   = 6'($urandom_range(1, 24));
            inj = 1'($urandom_range(0, 1));
            pay.delete();
            for (int i = 0; i < int'(l); i++) pay.push_back(8'($urandom_range(0, 255)));
            build_exp(a, l, inj);
            send_pkt(a, l, inj, 1, 1);
            checks++; if (timed_out || obs_d.size() != exp_d.size())
                $display("FAIL rand%0d_len: got %0d bytes expected %0d", n, obs_d.size(), exp_d.size()); else passed++;
            for (int i = 0; i < obs_d.size() && i < exp_d.size(); i++) begin
                checks++;
                if (obs_d[i] !== exp_d[i] || obs_v[i] !== exp_v[i])
                    $display("FAIL rand%0d_byte%0d: got %h/v%b expected %h/v%b", n, i, obs_d[i], obs_v[i], exp_d[i], exp_v[i]);
                else passed++;
            end
            checks++; if (hold_viol != 0 || srdy_viol != 0)
                $display("FAIL rand%0d_flow: got hold=%0d srdy=%0d violations expected 0/0", n, hold_viol, srdy_viol); else passed++;
            checks++; if (done_cnt != 1 || done_early != 0 || gap_seen != GAP)
                $display("FAIL rand%0d_done_gap: got done=%0d early=%0d gap=%0d expected 1/0/%0d", n, done_cnt, done_early, gap_seen, GAP);
            else passed++;
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_illegal();
        test_max_len();
        test_reset_mid();
        test_errinj();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
